// File: rtl/dffram_port_arbiter.sv
// rtl/dffram_port_arbiter.sv - shares the single-port DFFRAM between the CPU data port and a read-only housekeeping port
module dffram_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                core_clk,
    input  logic                core_rstn,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_di,
    output logic                cpu_gnt,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_do,
    input  logic                hk_req,
    input  logic [ADDR_W-1:0]   hk_addr,
    output logic                hk_gnt,
    output logic                hk_valid,
    output logic [DATA_W-1:0]   hk_data,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_a,
    output logic [DATA_W-1:0]   ram_di,
    input  logic [DATA_W-1:0]   ram_do
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HK   = 2'd2
    } owner_t;

    owner_t             owner_q, owner_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]  hk_data_q, hk_data_d;
    logic               hk_force;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
            hk_data_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            hk_data_q  <= hk_data_d;
        end
    end

    always_comb begin
        hk_force = hk_req & (wait_cnt_q >= MAX_WAIT_C);
        hk_gnt   = hk_req & (~cpu_en | hk_force);
        cpu_gnt  = cpu_en & ~hk_gnt;

        ram_en = cpu_gnt | hk_gnt;
        ram_a  = hk_gnt ? hk_addr : cpu_addr;
        ram_we = cpu_gnt ? cpu_we : '0;
        ram_di = cpu_di;

        wait_cnt_d = '0;
        if (hk_req && !hk_gnt) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
        end

        owner_d = OWN_NONE;
        if (cpu_gnt) begin
            owner_d = OWN_CPU;
        end else if (hk_gnt) begin
            owner_d = OWN_HK;
        end

        cpu_ack  = (owner_q == OWN_CPU);
        hk_valid = (owner_q == OWN_HK);
        cpu_do   = cpu_ack ? ram_do : '0;

        // ram_do only settles after the issue edge, so the valid cycle forwards it
        // and the register keeps it until the next housekeeping response.
        hk_data   = hk_valid ? ram_do : hk_data_q;
        hk_data_d = hk_data;
    end

endmodule

// File: tb/tb_dffram_port_arbiter.sv
// tb/tb_dffram_port_arbiter.sv - directed bench with a RAM model and a cycle-level reference of the arbiter
module tb_dffram_port_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              core_clk;
    logic              core_rstn;
    logic              cpu_en;
    logic [3:0]        cpu_we;
    logic [7:0]        cpu_addr;
    logic [31:0]       cpu_di;
    logic              cpu_gnt, cpu_ack;
    logic [31:0]       cpu_do;
    logic              hk_req;
    logic [7:0]        hk_addr;
    logic              hk_gnt, hk_valid;
    logic [31:0]       hk_data;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [7:0]        ram_a;
    logic [31:0]       ram_di;
    logic [31:0]       ram_do;

    int checks   = 0;
    int failures = 0;

    dffram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .core_clk(core_clk), .core_rstn(core_rstn),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_do(cpu_do),
        .hk_req(hk_req), .hk_addr(hk_addr), .hk_gnt(hk_gnt), .hk_valid(hk_valid), .hk_data(hk_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // Synchronous single-port RAM, read-before-write
    logic [31:0] ram_mem [256] = '{default: 32'h0};
    logic [31:0] ram_do_r = 32'h0;
    assign ram_do = ram_do_r;
    always @(posedge core_clk) begin
        if (ram_en) begin
            ram_do_r <= ram_mem[ram_a];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: who should own the RAM this cycle, what each requester should
    // receive next cycle, and the contents the RAM must hold.
    logic [31:0] model_mem [256] = '{default: 32'h0};
    int          streak = 0;
    bit          pend_cpu = 0, pend_cpu_rd = 0, pend_hk = 0;
    logic [31:0] pend_cpu_data = 0, pend_hk_data = 0, hk_hold = 0;
    bit          exp_hk, exp_cpu;

    always @(negedge core_clk) begin
        if (!core_rstn) begin
            pend_cpu = 0;
            pend_hk  = 0;
            hk_hold  = 0;
            streak   = 0;
        end
        if (pend_hk) hk_hold = pend_hk_data;
        chk("cpu_ack", 64'(cpu_ack), 64'(pend_cpu));
        chk("hk_valid", 64'(hk_valid), 64'(pend_hk));
        chk("hk_data", 64'(hk_data), 64'(hk_hold));
        if (!pend_cpu) chk("cpu_do_idle", 64'(cpu_do), 64'h0);
        else if (pend_cpu_rd) chk("cpu_do", 64'(cpu_do), 64'(pend_cpu_data));

        exp_hk  = hk_req && (!cpu_en || streak >= MAX_WAIT);
        exp_cpu = cpu_en && !exp_hk;
        chk("hk_gnt", 64'(hk_gnt), 64'(exp_hk));
        chk("cpu_gnt", 64'(cpu_gnt), 64'(exp_cpu));
        chk("ram_en", 64'(ram_en), 64'(exp_hk || exp_cpu));
        chk("ram_we", 64'(ram_we), exp_cpu ? 64'(cpu_we) : 64'h0);
        chk("ram_a", 64'(ram_a), exp_hk ? 64'(hk_addr) : 64'(cpu_addr));
        chk("ram_di", 64'(ram_di), 64'(cpu_di));

        if (!core_rstn) begin
            pend_cpu = 0;
            pend_hk  = 0;
            streak   = 0;
        end else begin
            pend_cpu      = exp_cpu;
            pend_cpu_rd   = (cpu_we == 4'h0);
            pend_cpu_data = model_mem[cpu_addr];
            pend_hk       = exp_hk;
            pend_hk_data  = model_mem[hk_addr];
            if (exp_cpu) begin
                for (int b = 0; b < 4; b++) begin
                    if (cpu_we[b]) model_mem[cpu_addr][8*b +: 8] = cpu_di[8*b +: 8];
                end
            end
            streak = (hk_req && !exp_hk) ? ((streak < 15) ? streak + 1 : 15) : 0;
        end
    end

    task automatic drive(input bit en, input logic [3:0] we, input logic [7:0] a, input logic [31:0] di,
                         input bit hr, input logic [7:0] ha);
        @(posedge core_clk);
        #1;
        cpu_en = en; cpu_we = we; cpu_addr = a; cpu_di = di;
        hk_req = hr; hk_addr = ha;
        @(negedge core_clk);
    endtask

    task automatic idle();
        drive(0, 4'h0, 8'h0, 32'h0, 0, 8'h0);
    endtask

    int k;

    initial begin
        core_rstn = 1'b0;
        cpu_en = 0; cpu_we = 0; cpu_addr = 0; cpu_di = 0; hk_req = 0; hk_addr = 0;
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_cpu_ack", 64'(cpu_ack), 64'h0);
        chk("rst_hk_data", 64'(hk_data), 64'h0);
        chk("rst_ram_en", 64'(ram_en), 64'h0);
        @(posedge core_clk);
        #1 core_rstn = 1'b1;

        // Full-word write then read-back
        drive(1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 8'h0);
        chk("wr_ram_en", 64'(ram_en), 64'h1);
        chk("wr_ram_we", 64'(ram_we), 64'hF);
        drive(1, 4'h0, 8'h10, 32'h0, 0, 8'h0);
        chk("wr_ack", 64'(cpu_ack), 64'h1);
        idle();
        chk("rd_ack", 64'(cpu_ack), 64'h1);
        chk("rd_data", 64'(cpu_do), 64'hDEADBEEF);

        // Byte-lane write
        drive(1, 4'b0010, 8'h10, 32'h0000AA00, 0, 8'h0);
        drive(1, 4'h0, 8'h10, 32'h0, 0, 8'h0);
        idle();
        chk("byte_rd", 64'(cpu_do), 64'hDEADAAEF);

        // Housekeeping read alone
        drive(0, 4'h0, 8'h0, 32'h0, 1, 8'h10);
        chk("hk_gnt_solo", 64'(hk_gnt), 64'h1);
        idle();
        chk("hk_valid_solo", 64'(hk_valid), 64'h1);
        chk("hk_data_solo", 64'(hk_data), 64'hDEADAAEF);
        idle();
        chk("hk_valid_drop", 64'(hk_valid), 64'h0);
        chk("hk_data_hold", 64'(hk_data), 64'hDEADAAEF);

        // Starvation: CPU writes back to back while housekeeping waits
        k = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'hF, 8'(8'h20 + k), 32'h10000000 + 32'(k), (i <= 4), 8'h10);
            if (i == 4) begin
                chk("starve_hk_gnt", 64'(hk_gnt), 64'h1);
                chk("starve_ram_we", 64'(ram_we), 64'h0);
            end else begin
                chk("starve_cpu_gnt", 64'(cpu_gnt), 64'h1);
                k++;
            end
            if (i == 5) begin
                chk("starve_hk_valid", 64'(hk_valid), 64'h1);
                chk("starve_hk_data", 64'(hk_data), 64'hDEADAAEF);
            end
        end
        idle();

        // Back-to-back CPU/HK interleave on distinct addresses
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0) drive(1, 4'h0, 8'(8'h20 + j / 2), 32'h0, 0, 8'h0);
            else            drive(0, 4'h0, 8'h0, 32'h0, 1, 8'(8'h23 - j / 2));
            if (j == 1) chk("ilv_cpu_do", 64'(cpu_do), 64'h10000000);
        end
        idle();
        chk("ilv_last_hk", 64'(hk_data), 64'h10000000);

        // CPU write then HK read of the same word
        drive(1, 4'hF, 8'h30, 32'hCAFEF00D, 0, 8'h0);
        drive(0, 4'h0, 8'h0, 32'h0, 1, 8'h30);
        idle();
        chk("raw_hk_data", 64'(hk_data), 64'hCAFEF00D);

        // Housekeeping withdraws before being granted
        drive(1, 4'h0, 8'h20, 32'h0, 1, 8'h31);
        drive(1, 4'h0, 8'h21, 32'h0, 1, 8'h31);
        drive(1, 4'h0, 8'h22, 32'h0, 0, 8'h0);
        idle();
        chk("withdraw_no_valid", 64'(hk_valid), 64'h0);

        // Reset while the wait counter is part-way up
        for (int i = 0; i < 3; i++) drive(1, 4'h0, 8'h20, 32'h0, 1, 8'h10);
        #2 core_rstn = 1'b0;
        idle();
        idle();
        @(posedge core_clk);
        #1 core_rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'h0, 8'h20, 32'h0, 1, 8'h10);
            chk("post_rst_hk_gnt", 64'(hk_gnt), (i == 4) ? 64'h1 : 64'h0);
        end
        idle();

        // Reset between hk_gnt and hk_valid
        drive(0, 4'h0, 8'h0, 32'h0, 1, 8'h30);
        chk("mid_hk_gnt", 64'(hk_gnt), 64'h1);
        #2 core_rstn = 1'b0;
        idle();
        chk("mid_no_valid", 64'(hk_valid), 64'h0);
        chk("mid_hk_data", 64'(hk_data), 64'h0);
        @(posedge core_clk);
        #1 core_rstn = 1'b1;
        idle();
        chk("mid_still_quiet", 64'(hk_valid), 64'h0);
        drive(0, 4'h0, 8'h0, 32'h0, 1, 8'h30);
        idle();
        chk("fresh_hk_valid", 64'(hk_valid), 64'h1);
        chk("fresh_hk_data", 64'(hk_data), 64'hCAFEF00D);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
